button_conditioner: RTL and testbench

//  Turns a raw, asynchronous, bouncing push-button input into clean, clk-synchronous signals.
//  - btn_pulse: exactly one cycle per debounced press; drives the `button` input of the ALU control FSM.
//  - btn_level: the debounced button level.
//  - Optional auto-repeat: re-issues btn_pulse while the button is held, to step through ALU functions.

---
 rtl/alu_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_conditioner.sv | 126 ++++++++++++
 tb/tb_button_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Types and default timing constants shared by the button conditioner and the ALU controller.
package alu_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 50_000_000;
  localparam int REPEAT_PERIOD_DEF   = 20_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button into a registered level and a one-cycle press strobe,
// with optional auto-repeat of the strobe while the button is held.
module button_conditioner
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic          btn_sync;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc, rpt_lim;
  logic          first_q, first_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_raw),
    .q     (btn_sync)
  );

  // Both counters saturate instead of wrapping.
  assign cnt_inc = (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q : cnt_q + CW'(1);
  assign rpt_inc = (rpt_q == RW'(RMAX)) ? rpt_q : rpt_q + RW'(1);
  // first_q selects the initial hold delay until the first repeat has fired.
  assign rpt_lim = first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    first_d = first_q;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_sync) begin
          state_d = RELEASED;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
          rpt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        // A repeat due on the exit edge is still issued.
        if (rpt_inc == rpt_lim) begin
          pulse_d = 1'b1;
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_inc;
        end
        if (!btn_sync) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_sync) begin
          state_d = PRESSED;
          rpt_d   = '0;
          first_d = 1'b1;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = RELEASED;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
    if (!REPEAT_EN) begin
      rpt_d   = '0;
      first_d = 1'b0;
      if (state_q == PRESSED) pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      rpt_q   <= '0;
      first_q <= 1'b0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner; two instances (without / with auto-repeat)
// share one raw input and are compared each cycle against a run-length reference model.
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int PER = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw = 1'b0;
  logic p0, l0, p1, l1;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .button_raw(raw), .btn_pulse(p0), .btn_level(l0));

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1),
                       .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut1 (
    .clk(clk), .reset(reset), .button_raw(raw), .btn_pulse(p1), .btn_level(l1));

  int n_checks = 0;
  int n_err    = 0;

  // Model: the level flips once the synchronized input has disagreed with it for D+1
  // consecutive samples; repeats fire DLY then every PER edges after (re)entering pressed.
  int edge_n = 0;
  bit m_s1, m_s2;
  bit m_lvl [2];
  int m_run [2];
  int m_anchor [2];
  bit m_pls [2];

  bit prev_p0, prev_p1, prev_l0, prev_l1;
  int npulse0 = 0, npulse1 = 0;
  int rise0 = -1, fall0 = -1, fall1 = -1;
  int pulse_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 1'b0; m_run[c] = 0; m_anchor[c] = 0; m_pls[c] = 1'b0;
    end
    prev_p0 = 1'b0; prev_p1 = 1'b0; prev_l0 = 1'b0; prev_l1 = 1'b0;
  endtask

  task automatic model_edge();
    bit seen, pl;
    int a;
    edge_n++;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    for (int c = 0; c < 2; c++) begin
      pl = 1'b0;
      if (c == 1 && m_lvl[c] && m_run[c] == 0) begin
        a = edge_n - m_anchor[c];
        if (a == DLY || (a > DLY && (a - DLY) % PER == 0)) pl = 1'b1;
      end
      if (seen != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D + 1) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
          if (m_lvl[c]) begin
            pl = 1'b1;
            m_anchor[c] = edge_n;
          end
        end
      end else begin
        if (m_lvl[c] && m_run[c] > 0) m_anchor[c] = edge_n;
        m_run[c] = 0;
      end
      m_pls[c] = pl;
    end
  endtask

  task automatic check_outputs();
    chk("pulse0", 32'(p0), 32'(m_pls[0]));
    chk("level0", 32'(l0), 32'(m_lvl[0]));
    chk("pulse1", 32'(p1), 32'(m_pls[1]));
    chk("level1", 32'(l1), 32'(m_lvl[1]));
    chk("no_double0", 32'(prev_p0 & p0), 32'(0));
    chk("no_double1", 32'(prev_p1 & p1), 32'(0));
    if (p0) npulse0++;
    if (p1) begin npulse1++; pulse_log.push_back(edge_n); end
    if (l0 && !prev_l0) rise0 = edge_n;
    if (!l0 && prev_l0) fall0 = edge_n;
    if (!l1 && prev_l1) fall1 = edge_n;
    prev_p0 = p0; prev_p1 = p1; prev_l0 = l0; prev_l1 = l1;
  endtask

  task automatic tick(input bit r);
    raw = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input bit r, input int n);
    for (int i = 0; i < n; i++) tick(r);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_pulse0", 32'(p0), 32'(0));
    chk("rst_level0", 32'(l0), 32'(0));
    chk("rst_pulse1", 32'(p1), 32'(0));
    chk("rst_level1", 32'(l1), 32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int mark, np0, np1, len;
    bit v;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_pulse0", 32'(p0), 32'(0));
    chk("init_level0", 32'(l0), 32'(0));
    chk("init_pulse1", 32'(p1), 32'(0));
    chk("init_level1", 32'(l1), 32'(0));
    reset = 1'b0;

    // Clean press and release
    mark = edge_n; np0 = npulse0; rise0 = -1; fall0 = -1;
    ticks(1'b1, 20);
    chk("t1_pulse_edge", 32'(rise0 - mark), 32'(7));
    chk("t1_pulse_count", 32'(npulse0 - np0), 32'(1));
    mark = edge_n; np0 = npulse0;
    ticks(1'b0, 12);
    chk("t1_release_edge", 32'(fall0 - mark), 32'(7));
    chk("t1_release_pulses", 32'(npulse0 - np0), 32'(0));

    // Press bounce
    np0 = npulse0;
    ticks(1'b1, 3);
    ticks(1'b0, 10);
    chk("t2_pulses", 32'(npulse0 - np0), 32'(0));
    chk("t2_level", 32'(l0), 32'(0));

    // Release bounce
    np0 = npulse0; fall0 = -1;
    ticks(1'b1, 12);
    ticks(1'b0, 2);
    ticks(1'b1, 10);
    chk("t3_level", 32'(l0), 32'(1));
    chk("t3_pulses", 32'(npulse0 - np0), 32'(1));
    chk("t3_no_fall", 32'(fall0), 32'(-1));
    ticks(1'b0, 12);

    // Reset mid-qualification with the button held
    ticks(1'b1, 5);
    do_reset();
    mark = edge_n; rise0 = -1;
    ticks(1'b1, 10);
    chk("t4_pulse_edge", 32'(rise0 - mark), 32'(7));
    ticks(1'b0, 12);

    // Auto-repeat
    mark = edge_n; fall1 = -1;
    pulse_log.delete();
    ticks(1'b1, 33);
    ticks(1'b0, 12);
    chk("t5_pulse_count", 32'(pulse_log.size()), 32'(5));
    if (pulse_log.size() == 5) begin
      chk("t5_pulse_a", 32'(pulse_log[0] - mark), 32'(7));
      chk("t5_pulse_b", 32'(pulse_log[1] - mark), 32'(17));
      chk("t5_pulse_c", 32'(pulse_log[2] - mark), 32'(22));
      chk("t5_pulse_d", 32'(pulse_log[3] - mark), 32'(27));
      chk("t5_pulse_e", 32'(pulse_log[4] - mark), 32'(32));
    end
    chk("t5_release_edge", 32'(fall1 - mark), 32'(40));

    // Chatter: runs of 1..3 cycles never qualify
    np0 = npulse0; np1 = npulse1;
    v = 1'b1;
    for (int i = 0; i < 1000; ) begin
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) tick(v);
      i += len;
      v = ~v;
    end
    ticks(1'b0, 12);
    chk("t6_pulses0", 32'(npulse0 - np0), 32'(0));
    chk("t6_pulses1", 32'(npulse1 - np1), 32'(0));

    // Random runs, some long enough to qualify
    for (int i = 0; i < 1500; ) begin
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) tick(v);
      i += len;
      v = ~v;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
